// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data memory block:
//   - access size encodings (byte / half / word / reserved)
//   - FSM state type (post-reset clearing, then ready)
//   - lane_extract(): pulls the addressed byte/half/word out of a memory word
//     and sign- or zero-extends it.
// lane_extract works on a fixed maximum width so it serves any DATA_W up to
// DM_MAX_W; callers zero-pad their word in and truncate the result back out.
// -----------------------------------------------------------------------------
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int DM_MAX_W     = 128;
    localparam int DM_MAX_OFF_W = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dm_state_e;

    function automatic logic [DM_MAX_W-1:0] lane_extract(
        input logic [DM_MAX_W-1:0]     word,
        input logic [DM_MAX_OFF_W-1:0] offset,
        input logic [1:0]              size,
        input logic                    is_unsigned
    );
        logic [DM_MAX_W-1:0] shifted;
        logic [DM_MAX_W-1:0] res;
        // Move the addressed byte lane down to bit 0.
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: res = is_unsigned ? {{(DM_MAX_W-8){1'b0}}, shifted[7:0]}
                                       : {{(DM_MAX_W-8){shifted[7]}}, shifted[7:0]};
            SZ_HALF: res = is_unsigned ? {{(DM_MAX_W-16){1'b0}}, shifted[15:0]}
                                       : {{(DM_MAX_W-16){shifted[15]}}, shifted[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dm_ram_bank.sv
// -----------------------------------------------------------------------------
// dm_ram_bank
// DEPTH x DATA_W storage with a byte-enable write port and a synchronous read
// port. Reads return the contents from before any write at the same edge
// (read-before-write). Array contents are never reset; only the read output
// register is, so the load result reads as zero straight out of reset.
// Ports:
//   clk      rising-edge clock
//   rst_n    async active-low reset (read output register only)
//   i_we     write enable
//   i_be     per-byte write enables
//   i_waddr  write word index
//   i_wdata  write data (already lane-placed)
//   i_re     read enable
//   i_raddr  read word index
//   o_rdata  registered read data (holds when i_re is low)
// -----------------------------------------------------------------------------
module dm_ram_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [NB-1:0]     i_be,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_ls.sv
// -----------------------------------------------------------------------------
// data_memory_ls
// Data memory with byte/half/word load-store, sign/zero extension and a
// one-cycle load latency. After reset the whole array is cleared one word per
// cycle (busy high, requests dropped). Misaligned or reserved-size requests are
// rejected with a one-cycle err pulse and have no effect.
// Ports:
//   clk          rising-edge clock
//   rst_n        async active-low reset
//   mem_read     load request
//   mem_write    store request
//   size         00 byte, 01 half, 10 word, 11 reserved
//   is_unsigned  1: zero-extend loads, 0: sign-extend
//   address      byte address (bits above the index wrap)
//   write_data   store data, right-aligned
//   read_data    extended load result
//   rd_valid     one-cycle pulse when read_data was updated
//   err          one-cycle pulse when the previous request was rejected
//   busy         clearing in progress
// -----------------------------------------------------------------------------
module data_memory_ls
    import dm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              rd_valid,
    output logic              err,
    output logic              busy
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    // ---------------- clear FSM ----------------
    dm_state_e        r_state;
    dm_state_e        w_state_next;
    logic [IDX_W-1:0] r_clr_idx;
    logic [IDX_W-1:0] w_clr_idx_next;
    logic             w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_idx <= w_clr_idx_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        w_busy         = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy         = 1'b1;
                w_clr_idx_next = r_clr_idx + 1'b1;
                if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                w_state_next = ST_READY;
            end
        endcase
    end

    // ---------------- request decode ----------------
    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_illegal;
    logic             w_req_ok;
    logic             w_rd_en;
    logic             w_wr_en;
    logic             w_err_next;

    assign w_off = address[OFF_W-1:0];
    assign w_idx = address[OFF_W +: IDX_W];

    always_comb begin
        w_illegal = 1'b0;
        case (size)
            SZ_BYTE: w_illegal = 1'b0;
            SZ_HALF: w_illegal = address[0];
            SZ_WORD: w_illegal = |w_off;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_req_ok   = ~w_busy & ~w_illegal;
    assign w_rd_en    = mem_read  & w_req_ok;
    assign w_wr_en    = mem_write & w_req_ok;
    assign w_err_next = ~w_busy & (mem_read | mem_write) & w_illegal;

    // ---------------- byte enables and lane placement ----------------
    logic [NB-1:0]     w_be_req;
    logic [DATA_W-1:0] w_wdata_req;

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        localparam logic [OFF_W-1:0] LANE = OFF_W'(gi);
        logic       w_lane_be;
        logic [7:0] w_lane_data;

        always_comb begin
            w_lane_be   = 1'b0;
            w_lane_data = write_data[gi*8 +: 8];
            case (size)
                SZ_BYTE: begin
                    w_lane_be   = (w_off == LANE);
                    w_lane_data = write_data[7:0];
                end
                SZ_HALF: begin
                    // Lanes pair up; the low/high byte of the half goes to the
                    // even/odd lane of the selected pair.
                    w_lane_be   = ((w_off >> 1) == (LANE >> 1));
                    w_lane_data = write_data[(gi % 2)*8 +: 8];
                end
                SZ_WORD: begin
                    w_lane_be   = 1'b1;
                end
                default: begin
                    w_lane_be   = 1'b0;
                end
            endcase
        end

        assign w_be_req[gi]          = w_lane_be;
        assign w_wdata_req[gi*8 +: 8] = w_lane_data;
    end

    // Clearing owns the write port while busy.
    logic              w_bank_we;
    logic [NB-1:0]     w_bank_be;
    logic [DATA_W-1:0] w_bank_wdata;
    logic [IDX_W-1:0]  w_bank_waddr;
    logic [DATA_W-1:0] w_bank_rdata;

    assign w_bank_we    = w_busy | w_wr_en;
    assign w_bank_be    = w_busy ? {NB{1'b1}} : w_be_req;
    assign w_bank_wdata = w_busy ? '0 : w_wdata_req;
    assign w_bank_waddr = w_busy ? r_clr_idx : w_idx;

    dm_ram_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .NB     (NB)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_bank_we),
        .i_be    (w_bank_be),
        .i_waddr (w_bank_waddr),
        .i_wdata (w_bank_wdata),
        .i_re    (w_rd_en),
        .i_raddr (w_idx),
        .o_rdata (w_bank_rdata)
    );

    // ---------------- output registers ----------------
    logic             r_rd_valid;
    logic             r_err;
    logic [OFF_W-1:0] r_rd_off;
    logic [1:0]       r_rd_size;
    logic             r_rd_uns;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_rd_off   <= '0;
            r_rd_size  <= SZ_WORD;
            r_rd_uns   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            r_err      <= w_err_next;
            if (w_rd_en) begin
                r_rd_off  <= w_off;
                r_rd_size <= size;
                r_rd_uns  <= is_unsigned;
            end
        end
    end

    // The bank word and the lane controls are both registered and only move
    // on an accepted load, so read_data holds between loads.
    logic [DM_MAX_W-1:0]     w_word_pad;
    logic [DM_MAX_OFF_W-1:0] w_off_pad;
    logic [DM_MAX_W-1:0]     w_ext_full;

    always_comb begin
        w_word_pad              = '0;
        w_word_pad[DATA_W-1:0]  = w_bank_rdata;
        w_off_pad               = '0;
        w_off_pad[OFF_W-1:0]    = r_rd_off;
    end

    assign w_ext_full = lane_extract(w_word_pad, w_off_pad, r_rd_size, r_rd_uns);

    assign read_data = w_ext_full[DATA_W-1:0];
    assign rd_valid  = r_rd_valid;
    assign err       = r_err;
    assign busy      = w_busy;

    // High address bits wrap and extension bits above DATA_W are discarded.
    logic w_unused_ok;
    assign w_unused_ok = ^{address, w_ext_full};

endmodule

// File: tb/tb_data_memory_ls.sv
module tb_data_memory_ls;
    import dm_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              is_unsigned = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic [DATA_W-1:0] read_data;
    logic              rd_valid;
    logic              err;
    logic              busy;

    data_memory_ls #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .size        (size),
        .is_unsigned (is_unsigned),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .rd_valid    (rd_valid),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic        rv;
        logic        er;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_last = '0;
    bit          mon_en = 1'b0;

    // Each queued entry describes the outputs expected just after the edge
    // that samples the corresponding request.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (mon_en && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({e.tag, "/rd_valid"}, 32'(rd_valid), 32'(e.rv));
            check_val({e.tag, "/err"}, 32'(err), 32'(e.er));
            check_val({e.tag, "/data"}, read_data, e.data);
            check_val({e.tag, "/busy"}, 32'(busy), 32'd0);
            $display("txn %-22s rd_valid=%0b err=%0b read_data=0x%08h", e.tag, rd_valid, err, read_data);
        end
    end

    task automatic req(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                       input bit exp_rv, input bit exp_er, input logic [31:0] exp_data);
        exp_t e;
        @(negedge clk);
        mem_read    = rd;
        mem_write   = wr;
        size        = sz;
        is_unsigned = uns;
        address     = addr;
        write_data  = wd;
        if (exp_rv) exp_last = exp_data;
        e.tag  = tag;
        e.rv   = exp_rv;
        e.er   = exp_er;
        e.data = exp_last;
        sb_q.push_back(e);
    endtask

    task automatic idle(input string tag);
        req(tag, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        check_val("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // Counts cycles with busy high starting at the current (release) negedge,
    // issuing loads throughout that must be ignored. Stops early at stop_at.
    task automatic count_busy(input int stop_at, output int cnt, output bit spurious);
        cnt = 0;
        spurious = 1'b0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            #1;
            if (!busy) break;
            cnt++;
            if (rd_valid || err) spurious = 1'b1;
            if (stop_at != 0 && cnt == stop_at) break;
            mem_read = 1'b1;
            size     = SZ_WORD;
            address  = 32'h0;
            @(negedge clk);
        end
        if (rd_valid || err) spurious = 1'b1;
        mem_read = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cnt;
        bit spur;

        // ---- 1: reset and clear ----
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst/read_data", read_data, 32'h0);
        check_val("rst/rd_valid", 32'(rd_valid), 32'd0);
        check_val("rst/err", 32'(err), 32'd0);
        check_val("rst/busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        count_busy(0, cnt, spur);
        check_val("clear/busy_cycles", 32'(cnt), 32'(DEPTH));
        check_val("clear/dropped_reqs", 32'(spur), 32'd0);
        $display("txn clear                  busy_cycles=%0d", cnt);

        mon_en = 1'b1;
        req("T1 LW 0x10", 1, 0, SZ_WORD, 0, 32'h10, 32'h0, 1, 0, 32'h0);
        idle("T1 idle");

        // ---- 2: byte/half loads with extension ----
        req("T2 SW 0x20", 0, 1, SZ_WORD, 0, 32'h20, 32'h8081_82F3, 0, 0, 32'h0);
        req("T2 LB 0x20", 1, 0, SZ_BYTE, 0, 32'h20, 32'h0, 1, 0, 32'hFFFF_FFF3);
        req("T2 LBU 0x23", 1, 0, SZ_BYTE, 1, 32'h23, 32'h0, 1, 0, 32'h0000_0080);
        req("T2 LH 0x22", 1, 0, SZ_HALF, 0, 32'h22, 32'h0, 1, 0, 32'hFFFF_8081);
        req("T2 LHU 0x20", 1, 0, SZ_HALF, 1, 32'h20, 32'h0, 1, 0, 32'h0000_82F3);
        idle("T2 idle hold");

        // ---- 3: partial store ----
        req("T3 SW 0x40", 0, 1, SZ_WORD, 0, 32'h40, 32'h1122_3344, 0, 0, 32'h0);
        req("T3 SB 0x41", 0, 1, SZ_BYTE, 0, 32'h41, 32'h0000_00AB, 0, 0, 32'h0);
        req("T3 LW 0x40", 1, 0, SZ_WORD, 0, 32'h40, 32'h0, 1, 0, 32'h1122_AB44);
        req("T3 SH 0x46", 0, 1, SZ_HALF, 0, 32'h46, 32'hFFFF_BEEF, 0, 0, 32'h0);
        req("T3 LW 0x44", 1, 0, SZ_WORD, 0, 32'h44, 32'h0, 1, 0, 32'hBEEF_0000);

        // ---- 4: misaligned / reserved ----
        req("T4 LW 0x42", 1, 0, SZ_WORD, 0, 32'h42, 32'h0, 0, 1, 32'h0);
        req("T4 SH 0x43", 0, 1, SZ_HALF, 0, 32'h43, 32'h0000_5555, 0, 1, 32'h0);
        req("T4 RSVD 0x0", 1, 0, SZ_RSVD, 0, 32'h0, 32'h0, 0, 1, 32'h0);
        req("T4 LW 0x40", 1, 0, SZ_WORD, 0, 32'h40, 32'h0, 1, 0, 32'h1122_AB44);

        // ---- 5: read-before-write, store then load, wrap ----
        req("T5 SW 0x60", 0, 1, SZ_WORD, 0, 32'h60, 32'h5, 0, 0, 32'h0);
        req("T5 RW 0x60", 1, 1, SZ_WORD, 0, 32'h60, 32'h9, 1, 0, 32'h5);
        req("T5 LW 0x60", 1, 0, SZ_WORD, 0, 32'h60, 32'h0, 1, 0, 32'h9);
        req("T5 LW wrap", 1, 0, SZ_WORD, 0, 32'(DEPTH * 4 + 'h60), 32'h0, 1, 0, 32'h9);
        idle("T5 idle");
        drain();

        // ---- 6: reset in the middle of clearing ----
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_last = '0;
        count_busy(DEPTH / 2, cnt, spur);
        check_val("T6 first_half", 32'(cnt), 32'(DEPTH / 2));
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("T6 rst/busy", 32'(busy), 32'd1);
        check_val("T6 rst/read_data", read_data, 32'h0);
        rst_n = 1'b1;
        count_busy(0, cnt, spur);
        check_val("T6 busy_cycles", 32'(cnt), 32'(DEPTH));
        check_val("T6 dropped_reqs", 32'(spur), 32'd0);
        $display("txn reclear                busy_cycles=%0d", cnt);

        mon_en = 1'b1;
        req("T6 LW 0x60 cleared", 1, 0, SZ_WORD, 0, 32'h60, 32'h0, 1, 0, 32'h0);
        idle("T6 idle");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
